// File: rtl/matrix_inverse_seq.sv
// Sequential Gauss-Jordan inverse of an NxN signed fixed-point matrix, one element op per cycle.
// Optional partial pivoting (row swap on zero pivot) is enabled by MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN.
module matrix_inverse_seq #(
  parameter int unsigned N    = 5,
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         singular,
  output logic         busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned JW = $clog2(2 * N);
  localparam int unsigned W2 = 2 * W;
  localparam int unsigned QB = 2 * FRAC + 1;
  localparam int unsigned CW = $clog2(QB);

  localparam logic [IW-1:0] LAST_I = IW'(N - 1);
  localparam logic [JW-1:0] LAST_J = JW'(2 * N - 1);
  localparam logic [JW-1:0] N_J    = JW'(N);
  localparam logic [CW-1:0] QB_TOP = CW'(QB - 1);

  localparam logic signed [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [W2-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD,
    S_RECIP,
    S_NORM,
    S_ELIM,
    S_OUT,
`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
    S_SWAP,
`endif
    S_ERR
  } state_e;

  function automatic logic signed [W-1:0] sat_w(input logic signed [W2-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[W-1:0];
    if (v < SAT_MIN) return SAT_MIN[W-1:0];
    return v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] mul_sh(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
    return sat_w(p >>> FRAC);
  endfunction

  function automatic logic signed [W-1:0] sub_sat(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    return sat_w(W2'(a) - W2'(b));
  endfunction

  state_e              state_q;
  logic [IW-1:0]       row_q, col_q, k_q, i_q;
  logic [JW-1:0]       j_q;
  logic signed [W-1:0] f_q, recip_q;
  logic                div_busy_q, div_neg_q;
  logic [CW-1:0]       div_cnt_q;
  logic [W-1:0]        div_rem_q, div_dvs_q;
  logic [QB-2:0]       div_quo_q;
  logic                in_ready_q, out_valid_q, out_last_q, singular_q, busy_q;
  logic [W-1:0]        out_data_q;

  logic signed [W-1:0] a_q [N][N];
  logic signed [W-1:0] x_q [N][N];

  logic                 ld_fire_c, ld_last_c, rc_last_col_c;
  logic [IW-1:0]        rc_row_nx_c, rc_col_nx_c, col_c, i_first_c, i_nx_c, i_p1_c;
  logic                 is_a_c, elim_last_row_c;
  logic signed [W-1:0]  piv_c, prow_c, tgt_c, f_c, nrm_c, elim_c, recip_c;
  logic                 piv_zero_c, piv_neg_c, div_ge_c;
  logic [W-1:0]         piv_mag_c, rem_nx_c;
  logic [W:0]           rem_sh_c;
  logic [QB-1:0]        quo_nx_c;
  logic signed [W2-1:0] quo_s_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign singular  = singular_q;
  assign busy      = busy_q;

  // Shared row-major walker, element datapath and restoring-divider step.
  always_comb begin
    ld_fire_c     = (state_q == S_LOAD) && in_valid && in_ready_q;
    rc_last_col_c = (col_q == LAST_I);
    ld_last_c     = ld_fire_c && rc_last_col_c && (row_q == LAST_I);
    rc_col_nx_c   = rc_last_col_c ? '0 : col_q + IW'(1);
    rc_row_nx_c   = rc_last_col_c ? row_q + IW'(1) : row_q;

    is_a_c = (j_q < N_J);
    col_c  = is_a_c ? IW'(j_q) : IW'(j_q - N_J);
    prow_c = is_a_c ? a_q[k_q][col_c] : x_q[k_q][col_c];
    tgt_c  = is_a_c ? a_q[i_q][col_c] : x_q[i_q][col_c];
    f_c    = (j_q == '0) ? a_q[i_q][k_q] : f_q;
    nrm_c  = mul_sh(prow_c, recip_q);
    elim_c = sub_sat(tgt_c, mul_sh(f_c, prow_c));

    i_first_c       = (k_q == '0) ? IW'(1) : '0;
    i_p1_c          = i_q + IW'(1);
    i_nx_c          = (i_p1_c == k_q) ? i_p1_c + IW'(1) : i_p1_c;
    elim_last_row_c = (i_q == LAST_I) || ((i_p1_c == LAST_I) && (k_q == LAST_I));

    piv_c      = a_q[k_q][k_q];
    piv_zero_c = (piv_c == '0);
    piv_neg_c  = piv_c[W-1];
    piv_mag_c  = piv_neg_c ? -piv_c : piv_c;

    // Dividend is the constant 1<<2*FRAC, so only its MSB shifts in as a one.
    rem_sh_c = {div_rem_q, (div_cnt_q == QB_TOP)};
    div_ge_c = (rem_sh_c >= {1'b0, div_dvs_q});
    rem_nx_c = div_ge_c ? W'(rem_sh_c - {1'b0, div_dvs_q}) : W'(rem_sh_c);
    quo_nx_c = {div_quo_q, div_ge_c};
    quo_s_c  = W2'(quo_nx_c);
    recip_c  = sat_w(div_neg_q ? -quo_s_c : quo_s_c);
  end

`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
  logic [IW-1:0] swap_r_q;
  logic [IW-1:0] sw_row_c;
  logic          sw_found_c;

  // First row below k with a nonzero entry in column k.
  always_comb begin
    sw_found_c = 1'b0;
    sw_row_c   = '0;
    for (int r = int'(N) - 1; r >= 1; r--) begin
      if ((IW'(r) > k_q) && (a_q[IW'(r)][k_q] != '0)) begin
        sw_found_c = 1'b1;
        sw_row_c   = IW'(r);
      end
    end
  end
`endif

  // Matrix storage: written only by the active phase, never reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_fire_c) a_q[row_q][col_q] <= in_data;
      if (ld_last_c) begin
        for (int r = 0; r < int'(N); r++) begin
          for (int c = 0; c < int'(N); c++) begin
            x_q[IW'(r)][IW'(c)] <= (r == c) ? ONE : '0;
          end
        end
      end
      if (state_q == S_NORM) begin
        if (is_a_c) a_q[k_q][col_c] <= nrm_c;
        else        x_q[k_q][col_c] <= nrm_c;
      end
      if (state_q == S_ELIM) begin
        if (is_a_c) a_q[i_q][col_c] <= elim_c;
        else        x_q[i_q][col_c] <= elim_c;
      end
`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
      if (state_q == S_SWAP) begin
        if (is_a_c) begin
          a_q[k_q][col_c]      <= a_q[swap_r_q][col_c];
          a_q[swap_r_q][col_c] <= a_q[k_q][col_c];
        end else begin
          x_q[k_q][col_c]      <= x_q[swap_r_q][col_c];
          x_q[swap_r_q][col_c] <= x_q[k_q][col_c];
        end
      end
`endif
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      f_q         <= '0;
      recip_q     <= '0;
      div_busy_q  <= 1'b0;
      div_neg_q   <= 1'b0;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_dvs_q   <= '0;
      div_quo_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      singular_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
      swap_r_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          if (ld_fire_c) begin
            singular_q <= 1'b0;
            row_q      <= rc_row_nx_c;
            col_q      <= rc_col_nx_c;
            if (ld_last_c) begin
              row_q      <= '0;
              k_q        <= '0;
              div_busy_q <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= S_RECIP;
            end
          end
        end
        S_RECIP: begin
          if (!div_busy_q) begin
            if (piv_zero_c) begin
`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
              if (sw_found_c) begin
                swap_r_q <= sw_row_c;
                j_q      <= '0;
                state_q  <= S_SWAP;
              end else begin
                singular_q <= 1'b1;
                state_q    <= S_ERR;
              end
`else
              singular_q <= 1'b1;
              state_q    <= S_ERR;
`endif
            end else begin
              div_busy_q <= 1'b1;
              div_cnt_q  <= QB_TOP;
              div_rem_q  <= '0;
              div_quo_q  <= '0;
              div_dvs_q  <= piv_mag_c;
              div_neg_q  <= piv_neg_c;
            end
          end else begin
            div_rem_q <= rem_nx_c;
            div_quo_q <= quo_nx_c[QB-2:0];
            div_cnt_q <= div_cnt_q - CW'(1);
            if (div_cnt_q == '0) begin
              recip_q    <= recip_c;
              div_busy_q <= 1'b0;
              j_q        <= '0;
              state_q    <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (j_q == LAST_J) begin
            j_q     <= '0;
            i_q     <= i_first_c;
            state_q <= S_ELIM;
          end else begin
            j_q <= j_q + JW'(1);
          end
        end
        S_ELIM: begin
          if (j_q == '0) f_q <= f_c;
          if (j_q == LAST_J) begin
            j_q <= '0;
            if (elim_last_row_c) begin
              if (k_q == LAST_I) begin
                row_q   <= '0;
                col_q   <= '0;
                state_q <= S_OUT;
              end else begin
                k_q     <= k_q + IW'(1);
                state_q <= S_RECIP;
              end
            end else begin
              i_q <= i_nx_c;
            end
          end else begin
            j_q <= j_q + JW'(1);
          end
        end
        S_OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= x_q[0][0];
            out_last_q  <= 1'b0;
          end else if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              row_q       <= '0;
              col_q       <= '0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_LOAD;
            end else begin
              row_q      <= rc_row_nx_c;
              col_q      <= rc_col_nx_c;
              out_data_q <= x_q[rc_row_nx_c][rc_col_nx_c];
              out_last_q <= (rc_row_nx_c == LAST_I) && (rc_col_nx_c == LAST_I);
            end
          end
        end
`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
        S_SWAP: begin
          if (j_q == LAST_J) begin
            j_q        <= '0;
            div_busy_q <= 1'b0;
            state_q    <= S_RECIP;
          end else begin
            j_q <= j_q + JW'(1);
          end
        end
`endif
        S_ERR: begin
          row_q      <= '0;
          col_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_inverse_seq.sv
// Directed bench for matrix_inverse_seq: N=5 main instance plus an N=2 instance for the pivot case.
module tb_matrix_inverse_seq;

  localparam int NN = 25;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_last, singular, busy;
  logic [15:0] in_data, out_data;
  logic        in2_valid, in2_ready, out2_valid, out2_ready, out2_last, singular2, busy2;
  logic [15:0] in2_data, out2_data;

  int          n_cmp = 0;
  int          n_err = 0;
  int          got2, cyc2, seen2;
  logic [15:0] mat  [NN];
  logic [15:0] expv [NN];
  logic [15:0] m2   [4];
  logic [15:0] e2   [4];

  matrix_inverse_seq u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .singular(singular), .busy(busy)
  );

  matrix_inverse_seq #(.N(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data),
    .out_last(out2_last), .singular(singular2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_diag(input logic [15:0] d, input logic [15:0] e);
    for (int i = 0; i < NN; i++) begin
      mat[i]  = (i % 6 == 0) ? d : 16'h0000;
      expv[i] = (i % 6 == 0) ? e : 16'h0000;
    end
  endtask

  task automatic load_mat(input int nelem, input bit gaps);
    for (int i = 0; i < nelem; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        tick();
      end
      check($sformatf("load_ready[%0d]", i), in_ready, 1);
      in_valid = 1'b1;
      in_data  = mat[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  task automatic collect(input string tag, input bit stall);
    int          got, cyc, ph;
    bit          held;
    logic [15:0] held_d;
    logic        held_l;
    got = 0; cyc = 0; ph = 0; held = 0; held_d = '0; held_l = 1'b0;
    while (got < NN && cyc < 4000) begin
      out_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      if (held && out_valid) begin
        check($sformatf("%s_hold_data[%0d]", tag, got), out_data, held_d);
        check($sformatf("%s_hold_last[%0d]", tag, got), out_last, held_l);
      end
      if (out_valid && out_ready) begin
        check($sformatf("%s_data[%0d]", tag, got), out_data, expv[got]);
        check($sformatf("%s_last[%0d]", tag, got), out_last, (got == NN - 1));
        got++;
        held = 0;
      end else if (out_valid) begin
        held   = 1;
        held_d = out_data;
        held_l = out_last;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_count"}, got, NN);
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_end_ready"}, in_ready, 1);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_singular"}, singular, 0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      if (out_valid) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in2_valid = 1'b0; in2_data = '0; out2_ready = 1'b0;
    m2 = '{16'h0000, 16'h0100, 16'h0100, 16'h0000};
    e2 = '{16'h0000, 16'h0100, 16'h0100, 16'h0000};
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_singular", singular, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // All-zero matrix: singular, back to LOAD two cycles after RECIP
    set_diag(16'h0000, 16'h0000);
    load_mat(NN, 0);
    check("zero_busy_recip", busy, 1);
    check("zero_ready_recip", in_ready, 0);
    tick();
    check("zero_singular_err", singular, 1);
    check("zero_ready_err", in_ready, 0);
    tick();
    check("zero_ready_load", in_ready, 1);
    check("zero_busy_load", busy, 0);
    watch_quiet("zero_no_valid", 40);
    check("zero_singular_hold", singular, 1);

    // Identity
    set_diag(16'h0100, 16'h0100);
    load_mat(NN, 0);
    check("ident_singular_clr", singular, 0);
    check("ident_busy", busy, 1);
    collect("ident", 0);

    // diag(2.0) with junk offered on in_data during compute
    set_diag(16'h0200, 16'h0080);
    load_mat(NN, 0);
    in_valid = 1'b1;
    in_data  = 16'h7777;
    collect("diag2", 0);
    in_valid = 1'b0;
    in_data  = 16'h0000;

    // A = I + e01 + 2*e20, loaded with in_valid gaps
    set_diag(16'h0100, 16'h0100);
    mat[1]   = 16'h0100;
    mat[10]  = 16'h0200;
    expv[1]  = 16'hFF00;
    expv[10] = 16'hFE00;
    expv[11] = 16'h0200;
    load_mat(NN, 1);
    collect("tri", 0);

    // Identity with out_ready 1-0-0-1 backpressure
    set_diag(16'h0100, 16'h0100);
    load_mat(NN, 0);
    collect("stall", 1);

    // Reset after 12 load elements, then diag(2.0)
    set_diag(16'h0100, 16'h0100);
    load_mat(12, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstld_ready", in_ready, 1);
    check("rstld_busy", busy, 0);
    check("rstld_valid", out_valid, 0);
    set_diag(16'h0200, 16'h0080);
    load_mat(NN, 0);
    collect("rstld", 0);

    // Reset mid-compute discards the matrix
    set_diag(16'h0100, 16'h0100);
    load_mat(NN, 0);
    repeat (30) tick();
    check("rstcmp_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstcmp_busy", busy, 0);
    watch_quiet("rstcmp_quiet", 500);

    // N=2 permutation matrix [[0,1],[1,0]]
    for (int i = 0; i < 4; i++) begin
      check($sformatf("n2_load_ready[%0d]", i), in2_ready, 1);
      in2_valid = 1'b1;
      in2_data  = m2[i];
      tick();
    end
    in2_valid = 1'b0;
    in2_data  = 16'h0000;
`ifdef MATRIX_INVERSE_SEQ_PIVOT_SWAP_EN
    got2 = 0;
    cyc2 = 0;
    out2_ready = 1'b1;
    while (got2 < 4 && cyc2 < 2000) begin
      if (out2_valid) begin
        check($sformatf("n2_data[%0d]", got2), out2_data, e2[got2]);
        check($sformatf("n2_last[%0d]", got2), out2_last, (got2 == 3));
        got2++;
      end
      tick();
      cyc2++;
    end
    out2_ready = 1'b0;
    check("n2_count", got2, 4);
    check("n2_singular", singular2, 0);
    check("n2_end_ready", in2_ready, 1);
`else
    tick();
    check("n2_singular", singular2, 1);
    tick();
    check("n2_ready", in2_ready, 1);
    seen2 = 0;
    repeat (50) begin
      if (out2_valid) seen2++;
      tick();
    end
    check("n2_no_valid", seen2, 0);
    check("n2_singular_hold", singular2, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
